// File: rtl/core_regs_pkg.sv
// Shared definitions for the core register bank and its read selector.
// Holds the 8-bit register code space, the datapath width and the
// increment-target helper used by the bus-write decoder.
package core_regs_pkg;

  localparam int DATA_W = 16;

  // Register codes, shared between the bus-write decoder and the read selector
  localparam logic [7:0] SEL_N       = 8'd1;
  localparam logic [7:0] SEL_M       = 8'd2;
  localparam logic [7:0] SEL_P       = 8'd3;
  localparam logic [7:0] SEL_R1      = 8'd4;
  localparam logic [7:0] SEL_ROW     = 8'd5;
  localparam logic [7:0] SEL_COL     = 8'd6;
  localparam logic [7:0] SEL_CURR    = 8'd7;
  localparam logic [7:0] SEL_SUM     = 8'd8;
  localparam logic [7:0] SEL_STA     = 8'd9;
  localparam logic [7:0] SEL_STB     = 8'd10;
  localparam logic [7:0] SEL_STC     = 8'd11;
  localparam logic [7:0] SEL_A       = 8'd12;
  localparam logic [7:0] SEL_B       = 8'd13;
  localparam logic [7:0] SEL_R       = 8'd14;
  localparam logic [7:0] SEL_CORE_ID = 8'd15;

  // Number of bus-writable registers (codes SEL_N..SEL_R)
  localparam int NUM_WR = 14;

  // Loop/index registers that support in-place increment: R1, ROW, COL, CURR
  function automatic logic is_inc_target(input logic [7:0] code);
    return (code >= SEL_R1) && (code <= SEL_CURR);
  endfunction

endpackage

// File: rtl/wfb_cnt_reg.sv
// Purpose: one DATA_W register with synchronous clear, bus load and +1 increment.
// Latency: one cycle from ld/inc to q.
// Backpressure: none; every ld/inc is applied in the cycle it is presented.
//
// Ports: clk, rst (sync, active-high), clr, ld (load d), inc (q+1), d, q.
// Priority: rst > clr > ld > inc, so a load in the same cycle discards the increment.
module wfb_cnt_reg
  import core_regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic              inc,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (inc) begin
      // Wraps naturally from all-ones to zero
      q <= q + DATA_W'(1);
    end
  end

endmodule

// File: rtl/wfb_decoder.sv
// Purpose: bus-write register bank; latches datain into the register picked by wfb_sel.
// Latency: one cycle; a write at edge k is visible on reg_* right after edge k.
// Backpressure: none; every write/increment strobe is accepted in its cycle.
//
// Ports: clk, rst (sync, active-high), wfb_en/wfb_sel/datain (bus write),
//   inc_en/inc_sel (increment, only with WFB_INC_EN), clr (clear writable regs),
//   reg_N..reg_R (14 writable registers), reg_CoreID (constant), sel_err (sticky).
// Build option: define WFB_INC_EN to add the increment ports and logic for
//   R1, ROW, COL and CURR; otherwise those are plain bus-loaded registers.
module wfb_decoder
  import core_regs_pkg::*;
#(
  parameter logic [DATA_W-1:0] CORE_ID = 16'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wfb_en,
  input  logic [7:0]        wfb_sel,
  input  logic [DATA_W-1:0] datain,
`ifdef WFB_INC_EN
  input  logic              inc_en,
  input  logic [7:0]        inc_sel,
`endif
  input  logic              clr,
  output logic [DATA_W-1:0] reg_N,
  output logic [DATA_W-1:0] reg_M,
  output logic [DATA_W-1:0] reg_P,
  output logic [DATA_W-1:0] reg_R1,
  output logic [DATA_W-1:0] reg_ROW,
  output logic [DATA_W-1:0] reg_COL,
  output logic [DATA_W-1:0] reg_CURR,
  output logic [DATA_W-1:0] reg_SUM,
  output logic [DATA_W-1:0] reg_STA,
  output logic [DATA_W-1:0] reg_STB,
  output logic [DATA_W-1:0] reg_STC,
  output logic [DATA_W-1:0] reg_A,
  output logic [DATA_W-1:0] reg_B,
  output logic [DATA_W-1:0] reg_R,
  output logic [DATA_W-1:0] reg_CoreID,
  output logic              sel_err
);

  // Only codes N..R are writable; 0, CoreID (15) and anything above are illegal
  logic wr_legal;
  logic wr_illegal;
  assign wr_legal   = wfb_en && (wfb_sel >= SEL_N) && (wfb_sel <= SEL_R);
  assign wr_illegal = wfb_en && !wr_legal;

  logic inc_illegal;
`ifdef WFB_INC_EN
  logic inc_legal;
  assign inc_legal   = inc_en && is_inc_target(inc_sel);
  assign inc_illegal = inc_en && !inc_legal;
`else
  assign inc_illegal = 1'b0;
`endif

  logic [DATA_W-1:0] reg_q [1:NUM_WR];

  for (genvar i = 1; i <= NUM_WR; i++) begin : g_reg
    logic              ld;
    logic [DATA_W-1:0] q;
    assign ld = wr_legal && (wfb_sel == 8'(i));

    if (is_inc_target(8'(i))) begin : g_cnt
      logic inc;
`ifdef WFB_INC_EN
      assign inc = inc_legal && (inc_sel == 8'(i));
`else
      assign inc = 1'b0;
`endif
      wfb_cnt_reg u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .ld  (ld),
        .inc (inc),
        .d   (datain),
        .q   (q)
      );
    end else begin : g_flop
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          q <= '0;
        end else if (ld) begin
          q <= datain;
        end
      end
    end

    assign reg_q[i] = q;
  end

  // CoreID only ever takes its reset value; clr and bus writes never touch it
  logic [DATA_W-1:0] core_id_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      core_id_q <= CORE_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sel_err <= 1'b0;
    end else if (wr_illegal || inc_illegal) begin
      sel_err <= 1'b1;
    end
  end

  assign reg_N      = reg_q[1];
  assign reg_M      = reg_q[2];
  assign reg_P      = reg_q[3];
  assign reg_R1     = reg_q[4];
  assign reg_ROW    = reg_q[5];
  assign reg_COL    = reg_q[6];
  assign reg_CURR   = reg_q[7];
  assign reg_SUM    = reg_q[8];
  assign reg_STA    = reg_q[9];
  assign reg_STB    = reg_q[10];
  assign reg_STC    = reg_q[11];
  assign reg_A      = reg_q[12];
  assign reg_B      = reg_q[13];
  assign reg_R      = reg_q[14];
  assign reg_CoreID = core_id_q;

endmodule

// File: tb/tb_wfb_decoder.sv
// Bench for wfb_decoder: drives one operation per cycle, pushes the expected
// register-bank snapshot into a queue and compares it after the edge.
// Increment scenarios are exercised only when WFB_INC_EN is defined.
module tb_wfb_decoder;
  import core_regs_pkg::*;

  localparam logic [15:0] TB_CORE_ID = 16'h0003;

  typedef struct packed {
    logic [14:0][15:0] r;   // index 0..13 = codes 1..14, index 14 = CoreID
    logic              err;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wfb_en = 1'b0;
  logic [7:0]  wfb_sel = 8'd0;
  logic [15:0] datain = 16'd0;
  logic        inc_en = 1'b0;
  logic [7:0]  inc_sel = 8'd0;
  logic        clr = 1'b0;
  logic [15:0] reg_N, reg_M, reg_P, reg_R1, reg_ROW, reg_COL, reg_CURR;
  logic [15:0] reg_SUM, reg_STA, reg_STB, reg_STC, reg_A, reg_B, reg_R, reg_CoreID;
  logic        sel_err;

  int n_chk  = 0;
  int n_pass = 0;

  snap_t model;
  snap_t exp_q[$];

  string names [15] = '{"N", "M", "P", "R1", "ROW", "COL", "CURR", "SUM",
                        "STA", "STB", "STC", "A", "B", "R", "CoreID"};

  wfb_decoder #(.CORE_ID(TB_CORE_ID)) dut (
    .clk        (clk),
    .rst        (rst),
    .wfb_en     (wfb_en),
    .wfb_sel    (wfb_sel),
    .datain     (datain),
`ifdef WFB_INC_EN
    .inc_en     (inc_en),
    .inc_sel    (inc_sel),
`endif
    .clr        (clr),
    .reg_N      (reg_N),
    .reg_M      (reg_M),
    .reg_P      (reg_P),
    .reg_R1     (reg_R1),
    .reg_ROW    (reg_ROW),
    .reg_COL    (reg_COL),
    .reg_CURR   (reg_CURR),
    .reg_SUM    (reg_SUM),
    .reg_STA    (reg_STA),
    .reg_STB    (reg_STB),
    .reg_STC    (reg_STC),
    .reg_A      (reg_A),
    .reg_B      (reg_B),
    .reg_R      (reg_R),
    .reg_CoreID (reg_CoreID),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, applied to the bench's own model
  task automatic model_edge(input logic r, input logic c, input logic wen,
                            input logic [7:0] wsel, input logic [15:0] wdat,
                            input logic ien, input logic [7:0] isel);
    snap_t nx;
    logic  wr_ok;
    nx = model;
    if (r) begin
      nx.r   = '0;
      nx.r[14] = TB_CORE_ID;
      nx.err = 1'b0;
    end else if (c) begin
      for (int k = 0; k < 14; k++) nx.r[k] = 16'h0000;
      nx.err = 1'b0;
    end else begin
      wr_ok = wen && (wsel >= 8'd1) && (wsel <= 8'd14);
      if (wr_ok) nx.r[wsel - 8'd1] = wdat;
      else if (wen) nx.err = 1'b1;
`ifdef WFB_INC_EN
      if (ien) begin
        if (isel >= 8'd4 && isel <= 8'd7) begin
          if (!(wr_ok && wsel == isel)) nx.r[isel - 8'd1] = model.r[isel - 8'd1] + 16'd1;
        end else begin
          nx.err = 1'b1;
        end
      end
`else
      if (ien && isel == 8'hFF) nx.err = nx.err;  // increment absent in this build
`endif
    end
    model = nx;
  endtask

  task automatic step(input logic r, input logic c, input logic wen,
                      input logic [7:0] wsel, input logic [15:0] wdat,
                      input logic ien, input logic [7:0] isel);
    snap_t e;
    snap_t o;
    @(negedge clk);
    rst = r; clr = c; wfb_en = wen; wfb_sel = wsel; datain = wdat;
    inc_en = ien; inc_sel = isel;
    model_edge(r, c, wen, wsel, wdat, ien, isel);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    o.r = {reg_CoreID, reg_R, reg_B, reg_A, reg_STC, reg_STB, reg_STA, reg_SUM,
           reg_CURR, reg_COL, reg_ROW, reg_R1, reg_P, reg_M, reg_N};
    o.err = sel_err;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      for (int k = 0; k < 15; k++) chk(names[k], o.r[k], e.r[k]);
      chk("sel_err", {15'd0, o.err}, {15'd0, e.err});
    end
  endtask

  task automatic wr(input logic [7:0] sel, input logic [15:0] dat);
    step(1'b0, 1'b0, 1'b1, sel, dat, 1'b0, 8'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 8'd0);
  endtask

  initial begin
    model = '0;
    // Reset state
    step(1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 8'd0);
    idle();

    // Write sweep over every writable code
    for (int code = 1; code <= 14; code++) wr(8'(code), 16'hA000 + 16'(code));
    idle();

    // Illegal writes: code 0, CoreID, out of range
    wr(8'd0, 16'hFFFF);
    wr(8'd15, 16'hFFFF);
    wr(8'd200, 16'hFFFF);
    idle();
    // clr clears the flag and the writable registers
    step(1'b0, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 8'd0);

    // Back-to-back writes to one register: last one wins
    wr(SEL_SUM, 16'h1111);
    wr(SEL_SUM, 16'h2222);

`ifdef WFB_INC_EN
    // Increment wrap on ROW
    wr(SEL_ROW, 16'hFFFE);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b1, SEL_ROW);
    // Same-target conflict: write wins
    step(1'b0, 1'b0, 1'b1, SEL_COL, 16'h0010, 1'b1, SEL_COL);
    // Different targets: both take effect
    wr(SEL_CURR, 16'h0005);
    step(1'b0, 1'b0, 1'b1, SEL_COL, 16'h0077, 1'b1, SEL_CURR);
    // Increment of a non-counter register is illegal
    step(1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b1, SEL_P);
    idle();
    // clr beats a simultaneous increment
    step(1'b0, 1'b1, 1'b0, 8'd0, 16'd0, 1'b1, SEL_R1);
`endif

    // rst beats a simultaneous write
    wr(SEL_N, 16'hBEEF);
    step(1'b1, 1'b0, 1'b1, SEL_N, 16'h1234, 1'b0, 8'd0);
    // clr beats a simultaneous write
    wr(SEL_A, 16'h1111);
    wr(SEL_B, 16'h3333);
    step(1'b0, 1'b1, 1'b1, SEL_A, 16'h55AA, 1'b0, 8'd0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
